// File: rtl/seq_mul_sa.sv
// seq_mul_sa : sequential radix-2 shift-add multiplier with valid/ready on
// both sides and optional two's-complement operands.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  operand handshake (ready only while idle)
//   a, b            multiplicand (A_WIDTH) and multiplier (B_WIDTH)
//   signed_mode     1 = operands are two's complement, 0 = unsigned
//   out_valid/ready result handshake, product held until accepted
//   product         A_WIDTH+B_WIDTH bit result
//
// One operation is in flight at a time. Magnitudes are multiplied unsigned
// over B_WIDTH iterations and the sign is applied in a final FIX cycle.
module seq_mul_sa #(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic                       signed_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int ACC_WIDTH = P_WIDTH + 1;
    localparam int CNT_WIDTH = $clog2(B_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [A_WIDTH-1:0]     mcand;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   neg;
    logic [CNT_WIDTH-1:0]   cnt;

    logic                   accept;
    logic                   a_neg;
    logic                   b_neg;
    logic [A_WIDTH-1:0]     a_abs;
    logic [B_WIDTH-1:0]     b_abs;
    logic [A_WIDTH:0]       sum;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;

    // The magnitude of the most negative value still fits when the result is
    // read back as unsigned, so no extra bit is needed for mcand or b.
    assign a_neg = signed_mode & a[A_WIDTH-1];
    assign b_neg = signed_mode & b[B_WIDTH-1];
    assign a_abs = a_neg ? ({A_WIDTH{1'b0}} - a) : a;
    assign b_abs = b_neg ? ({B_WIDTH{1'b0}} - b) : b;

    // Upper A_WIDTH+1 accumulator bits plus the multiplicand when the current
    // multiplier bit (acc[0]) is set; the upper part never overflows here.
    always_comb begin
        sum = acc[ACC_WIDTH-1:B_WIDTH];
        if (acc[0]) begin
            sum = acc[ACC_WIDTH-1:B_WIDTH] + {1'b0, mcand};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: RUN lasts exactly B_WIDTH cycles, FIX one cycle,
    // DONE until the consumer takes the product.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (cnt == CNT_WIDTH'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_valid & out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations, sign fix-up and the
    // output register that stays put until the handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= a_abs;
                        acc   <= {{(A_WIDTH+1){1'b0}}, b_abs};
                        neg   <= signed_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                        cnt   <= CNT_WIDTH'(B_WIDTH);
                    end
                end
                RUN: begin
                    acc <= {1'b0, sum, acc[B_WIDTH-1:1]};
                    cnt <= cnt - CNT_WIDTH'(1);
                end
                FIX: begin
                    product   <= neg ? ({P_WIDTH{1'b0}} - acc[P_WIDTH-1:0])
                                     : acc[P_WIDTH-1:0];
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_valid & out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
